// File: rtl/bcd_timer_display.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_display
// Description : Multi-digit BCD seconds timer with per-digit seven-segment
//               drive. Counts up or down once every CLK_FREQ clock cycles
//               while running. Supports start/pause/clear/load control,
//               a terminal-count pulse on down-count and a wrap pulse on
//               up-count.
//
// Parameters  : CLK_FREQ  - i_clk cycles per count step (>= 2)
//               N_DIGITS  - number of BCD digits (1..8), digit 0 is the LSD
//
// Ports       : i_clk       system clock
//               i_rst_n     asynchronous active-low reset
//               i_start     pulse: begin/resume counting
//               i_pause     pulse: hold the count
//               i_clear     pulse: zero all digits, return to IDLE
//               i_load      pulse: load i_load_val (nibbles >9 clamp to 9)
//               i_load_val  BCD preset, digit k at [4k+3:4k]
//               i_down      0 = count up, 1 = count down (sampled per step)
//               o_bcd       registered current count
//               o_seg       active-low {g,f,e,d,c,b,a}, digit k at [7k+6:7k]
//               o_running   high while counting
//               o_done      one-cycle pulse when a down-count reaches zero
//               o_wrap      one-cycle pulse when an up-count wraps to zero
//
// Build macro : LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//               (other than digit 0) are blanked on o_seg.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_timer_display #(
  parameter int CLK_FREQ = 50000000,
  parameter int N_DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_pause,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_load_val,
  input  logic                  i_down,
  output logic [4*N_DIGITS-1:0] o_bcd,
  output logic [7*N_DIGITS-1:0] o_seg,
  output logic                  o_running,
  output logic                  o_done,
  output logic                  o_wrap
);

  localparam int          c_BCD_W     = 4 * N_DIGITS;
  localparam logic [31:0] c_PRESC_MAX = 32'(CLK_FREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // BCD helpers
  // --------------------------------------------------------------------------
  function automatic logic [c_BCD_W-1:0] f_inc(input logic [c_BCD_W-1:0] v);
    logic [c_BCD_W-1:0] r;
    logic               c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (c) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [c_BCD_W-1:0] f_dec(input logic [c_BCD_W-1:0] v);
    logic [c_BCD_W-1:0] r;
    logic               b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [c_BCD_W-1:0] f_clamp(input logic [c_BCD_W-1:0] v);
    logic [c_BCD_W-1:0] r;
    for (int k = 0; k < N_DIGITS; k++) begin
      r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return blank ? 7'b1111111 : s;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_presc;
  logic [31:0]          w_presc_nxt;
  logic [c_BCD_W-1:0]   r_bcd;
  logic [c_BCD_W-1:0]   w_bcd_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_wrap;
  logic                 w_wrap_nxt;

  logic [c_BCD_W-1:0]   w_inc;
  logic [c_BCD_W-1:0]   w_dec;
  logic                 w_is_zero;

  assign w_inc     = f_inc(r_bcd);
  assign w_dec     = f_dec(r_bcd);
  assign w_is_zero = (r_bcd == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_bcd   <= w_bcd_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Control priority: clear > load > pause > start. A pause arriving on the
  // step cycle wins, so the step is deferred until the next resume.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_bcd_nxt   = r_bcd;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;

    if (i_clear) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_bcd_nxt   = '0;
    end else if (i_load) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_bcd_nxt   = f_clamp(i_load_val);
    end else begin
      case (r_state)
        S_IDLE: begin
          w_presc_nxt = '0;
          if (i_start) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (i_pause) begin
            w_state_nxt = S_PAUSE;
          end else if (r_presc == c_PRESC_MAX) begin
            w_presc_nxt = '0;
            if (i_down) begin
              // Never borrow below zero: a down step from zero just stops.
              if (w_is_zero) begin
                w_state_nxt = S_DONE;
              end else begin
                w_bcd_nxt = w_dec;
                if (w_dec == '0) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                end
              end
            end else begin
              // Incremented value is zero only when coming from all nines.
              w_bcd_nxt  = w_inc;
              w_wrap_nxt = (w_inc == '0);
            end
          end else begin
            w_presc_nxt = r_presc + 32'd1;
          end
        end
        S_PAUSE: begin
          if (i_start) begin
            w_state_nxt = S_RUN;
            w_presc_nxt = '0;
          end
        end
        S_DONE: begin
          w_presc_nxt = '0;
          if (i_start && (!w_is_zero || !i_down)) begin
            w_state_nxt = S_RUN;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Segment decode
  // --------------------------------------------------------------------------
  logic [N_DIGITS-1:0] w_blank;

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit downward; a digit is blanked while
  // it and every digit above it are zero. Digit 0 always shows.
  logic w_hi_zero;
  always_comb begin
    w_blank   = '0;
    w_hi_zero = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      w_hi_zero  = w_hi_zero && (r_bcd[4*k +: 4] == 4'd0);
      w_blank[k] = w_hi_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  genvar g;
  for (g = 0; g < N_DIGITS; g++) begin : g_digit
    assign o_seg[7*g +: 7] = f_seg(r_bcd[4*g +: 4], w_blank[g]);
  end

  assign o_bcd     = r_bcd;
  assign o_running = (r_state == S_RUN);
  assign o_done    = r_done;
  assign o_wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_timer_display
// Description : Self-checking bench for bcd_timer_display (CLK_FREQ=4,
//               N_DIGITS=4). A cycle reference model keeps the count as a
//               plain decimal integer and is compared with every output
//               after every clock edge; directed steps are followed by a
//               randomized control sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_timer_display;

  localparam int CF   = 4;
  localparam int ND   = 4;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic        down = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] bcd;
  logic [27:0] seg;
  logic        running;
  logic        done;
  logic        wrap;

  bcd_timer_display #(.CLK_FREQ(CF), .N_DIGITS(ND)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_pause    (pause),
    .i_clear    (clear),
    .i_load     (load),
    .i_load_val (load_val),
    .i_down     (down),
    .o_bcd      (bcd),
    .o_seg      (seg),
    .o_running  (running),
    .o_done     (done),
    .o_wrap     (wrap)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
  mst_t m_st;
  int   m_val;
  int   m_ph;
  bit   m_done;
  bit   m_wrap;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                7'b0110000, 7'b0011001, 7'b0010010,
                                7'b0000010, 7'b1111000, 7'b0000000,
                                7'b0010000};

  function automatic int clamp_val(input logic [15:0] v);
    int s = 0;
    int p = 1;
    for (int k = 0; k < ND; k++) begin
      int d = int'(v[4*k +: 4]);
      if (d > 9) d = 9;
      s += d * p;
      p *= 10;
    end
    return s;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] to_seg(input int v);
    logic [27:0] r;
    int          p = 1;
    int          x = v;
    for (int k = 0; k < ND; k++) begin
      bit blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) blank = 1'b1;
`endif
      r[7*k +: 7] = blank ? 7'b1111111 : seg_tab[x % 10];
      x = x / 10;
      p *= 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_val = 0; m_ph = 0; m_done = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step();
    if (down) begin
      if (m_val == 0) begin
        m_st = M_DONE;
      end else begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_st   = M_DONE;
          m_done = 1'b1;
        end
      end
    end else if (m_val == MAXV) begin
      m_val  = 0;
      m_wrap = 1'b1;
    end else begin
      m_val = m_val + 1;
    end
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (clear) begin
      m_st = M_IDLE; m_val = 0; m_ph = 0;
    end else if (load) begin
      m_st = M_IDLE; m_val = clamp_val(load_val); m_ph = 0;
    end else begin
      case (m_st)
        M_IDLE:  if (start) begin m_st = M_RUN; m_ph = 0; end
        M_RUN: begin
          if (pause) m_st = M_PAUSE;
          else if (m_ph == CF - 1) begin m_ph = 0; model_step(); end
          else m_ph++;
        end
        M_PAUSE: if (start) begin m_st = M_RUN; m_ph = 0; end
        M_DONE:  if (start && (m_val != 0 || !down)) begin m_st = M_RUN; m_ph = 0; end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  // ---------------------------------------------------------------- checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    chk({tag, "_bcd"},  32'(bcd),     32'(to_bcd(m_val)));
    chk({tag, "_seg"},  32'(seg),     32'(to_seg(m_val)));
    chk({tag, "_run"},  32'(running), 32'(m_st == M_RUN));
    chk({tag, "_done"}, 32'(done),    32'(m_done));
    chk({tag, "_wrap"}, 32'(wrap),    32'(m_wrap));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0;
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    model_reset();
    #12;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Up count: first step exactly CF cycles after start
    start = 1'b1; cyc("start_up");
    run(3, "up_wait");
    cyc("up_step1");
    chk("up_first_step", 32'(bcd), 32'h0001);
    run(4, "up_step2");
    chk("up_second_step", 32'(bcd), 32'h0002);
    chk("seg_two", 32'(seg[6:0]), 32'b0100100);

    // Up wrap from all nines
    load_val = 16'h9999; load = 1'b1; cyc("wrap_load");
    start = 1'b1; cyc("wrap_start");
    run(3, "wrap_wait");
    cyc("wrap_step");
    chk("wrap_pulse", 32'(wrap), 32'h1);
    chk("wrap_bcd", 32'(bcd), 32'h0);
    chk("wrap_running", 32'(running), 32'h1);
    cyc("wrap_after");
    chk("wrap_one_cycle", 32'(wrap), 32'h0);

    // Down count to zero, then a start is refused
    down = 1'b1;
    load_val = 16'h0010; load = 1'b1; cyc("dn_load");
    start = 1'b1; cyc("dn_start");
    run(40, "dn_count");
    chk("dn_done", 32'(done), 32'h1);
    chk("dn_bcd_zero", 32'(bcd), 32'h0);
    chk("dn_stopped", 32'(running), 32'h0);
    cyc("dn_after");
    chk("dn_done_one_cycle", 32'(done), 32'h0);
    start = 1'b1; cyc("dn_restart");
    chk("dn_stays_done", 32'(running), 32'h0);
    run(6, "dn_hold");

    // Pause two cycles into a step, hold, resume
    down = 1'b0;
    load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    load = 1'b1; cyc("ps_load");
    start = 1'b1; cyc("ps_start");
    run(2, "ps_run");
    pause = 1'b1; cyc("ps_pause");
    run(10, "ps_hold");
    start = 1'b1; cyc("ps_resume");
    run(4, "ps_after");

    // Priority and clamp
    clear = 1'b1; load = 1'b1; load_val = 16'h1234; cyc("prio");
    chk("prio_clear_wins", 32'(bcd), 32'h0);
    load = 1'b1; load_val = 16'h00F3; cyc("clamp");
    chk("clamp_val", 32'(bcd), 32'h0093);

    // Leading-zero display
    load = 1'b1; load_val = 16'h0050; cyc("lz_load");
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d3", 32'(seg[27:21]), 32'b1111111);
    chk("lz_d2", 32'(seg[20:14]), 32'b1111111);
`else
    chk("lz_d3", 32'(seg[27:21]), 32'b1000000);
    chk("lz_d2", 32'(seg[20:14]), 32'b1000000);
`endif
    chk("lz_d1", 32'(seg[13:7]), 32'b0010010);
    chk("lz_d0", 32'(seg[6:0]),  32'b1000000);

    // Asynchronous reset mid-count
    load = 1'b1; load_val = 16'h1234; cyc("ar_load");
    start = 1'b1; cyc("ar_start");
    run(5, "ar_run");
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized control sequence
    for (int i = 0; i < 800; i++) begin
      clear = ($urandom_range(0, 99) < 2);
      load  = ($urandom_range(0, 99) < 4);
      pause = ($urandom_range(0, 99) < 4);
      start = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 19) == 0) down = ~down;
      case ($urandom_range(0, 3))
        0:       load_val = 16'($urandom);
        1:       load_val = 16'h9998;
        default: load_val = {12'h000, 4'($urandom_range(0, 15))};
      endcase
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_timer_display.md
# bcd_timer_display

Multi-digit BCD seconds timer with seven-segment drive, the parametrised successor to the lab's fixed two-digit, free-running, up-only seconds counter. It adds a configurable digit count and clock rate, up/down mode, start/pause/clear/load control, terminal-count signalling, and per-digit segment decode. It sits between the board's button/switch synchroniser and the HEX display pins.

## Interface
- CLK_FREQ, 50000000, i_clk cycles per count step (≥2)
- N_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle pulse: begin/resume counting
- i_pause  in  1  one-cycle pulse: hold count
- i_clear  in  1  one-cycle pulse: zero all digits, go IDLE
- i_load  in  1  one-cycle pulse: load i_load_val, go IDLE
- i_load_val  in  4*N_DIGITS  BCD preset, digit k at [4k+3:4k]
- i_down  in  1  0 = count up, 1 = count down; sampled at every step
- o_bcd  out  4*N_DIGITS  registered current count
- o_seg  out  7*N_DIGITS  active-low segments {g,f,e,d,c,b,a} per digit, digit k at [7k+6:7k]
- o_running  out  1  high in RUN
- o_done  out  1  one-cycle pulse when a down-count reaches all zeros
- o_wrap  out  1  one-cycle pulse when an up-count wraps from all nines to all zeros

## Operation
- States: IDLE (reset state), RUN, PAUSE, DONE.
- IDLE --i_start--> RUN; RUN --i_pause--> PAUSE; PAUSE --i_start--> RUN; RUN --down-count reaches 0--> DONE; DONE --i_start--> RUN only if count ≠ 0 or i_down = 0, otherwise stays in DONE.
- i_clear or i_load in any state: go to IDLE. Priority when pulses coincide: i_clear > i_load > i_pause > i_start.
- Prescaler: 32-bit, counts 0..CLK_FREQ-1 only in RUN. Count step fires on the cycle the prescaler equals CLK_FREQ-1; the prescaler then returns to 0. It is zeroed on entry to RUN from any state, so the first step occurs exactly CLK_FREQ cycles after i_start. It holds in PAUSE and is zeroed in IDLE and DONE.
- Up step: BCD increment with ripple carry. At all nines, every digit goes to 0, o_wrap pulses, and the block stays in RUN.
- Down step: BCD decrement with ripple borrow. When the result is all zeros, enter DONE and pulse o_done in the same cycle the zero count is registered. A down step taken from all zeros does not occur: DONE is entered first.
- Load: any nibble >9 in i_load_val is clamped to 9.
- Segment decode, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.

## Timing
- Reset values: o_bcd = 0, state IDLE, prescaler 0, o_running = 0, o_done = 0, o_wrap = 0, every o_seg digit = 1000000 (or blank per Configuration).
- Control pulses take effect on the next rising edge. o_bcd and o_running update one cycle after the pulse.
- o_seg is combinational from o_bcd, so it has zero additional latency.
- o_done and o_wrap are registered, are high for exactly one cycle, and are aligned with the o_bcd update that caused them.
- i_down changed mid-RUN applies from the next step. The prescaler is not reset.
- i_pause while in IDLE/DONE, and i_start while in RUN, are ignored.
- Reset asserted mid-count returns all outputs to reset values immediately (asynchronously).

## Configuration
- LEADING_ZERO_BLANK_EN defined: any digit k>0 whose value is 0 and whose higher digits are all 0 drives blank on o_seg. Digit 0 is never blanked. o_bcd is unaffected.
- LEADING_ZERO_BLANK_EN undefined: every digit always shows its decoded value, including leading zeros.

## Test plan
- Reset, then i_start with CLK_FREQ=4, N_DIGITS=2, up: o_bcd=0x01 exactly 4 cycles after start, 0x02 after 8; o_seg[6:0]=0100100 at 0x02.
- Up wrap: load 0x99, start. After 4 cycles, o_bcd=0x00, o_wrap high one cycle, o_running stays 1.
- Down to zero: load 0x10, i_down=1, start. Count goes 0x09 … 0x00; at 0x00, o_done pulses once, state is DONE, o_running=0. A further i_start leaves the block in DONE.
- Pause/resume: pause 2 cycles into a step, hold 10 cycles, then start. The next step lands 4 cycles after resume and the count is unchanged during the pause.
- Priority and clamp: i_clear and i_load pulse together, giving o_bcd=0x00. i_load with 0xF3 gives o_bcd=0x93.
- LEADING_ZERO_BLANK_EN, N_DIGITS=4, o_bcd=0x0050: digits 3 and 2 are 1111111, digit 1 is 0010010, digit 0 is 1000000. Without the macro, digits 3 and 2 are 1000000.
